// File: rtl/bcd_display_scanner_pkg.sv
// Package bcd_display_pkg: shared types and constants for the BCD display
// scanner slice.
//   state_t     - scan FSM states (BLANK: all digits off, DRIVE: one digit on)
//   SEG_DIGITS  - segment patterns {g,f,e,d,c,b,a} for BCD 0..9, active-high
//   SEG_DASH    - pattern shown for illegal nibbles 10..15
//   SEG_OFF     - all segments dark
package bcd_display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_DIGITS [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD nibble to 7-segment decoder.
//   bcd - 4-bit input nibble
//   seg - segments {g,f,e,d,c,b,a}, active-high; illegal nibbles show a dash
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) begin
      seg = SEG_DIGITS[bcd];
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: accepts a packed BCD word over valid/ready and scans it
// onto a common-segment multiplexed 7-segment display, one digit at a time
// with a blanking gap before every digit. New words are taken only at the
// frame boundary (last DRIVE cycle of the most significant digit).
//   i_clk, i_aresetn - clock, asynchronous active-low reset
//   i_valid, o_ready - input handshake; transfer when both are high
//   i_bcd            - packed BCD, digit k in bits [4k+3:4k]
//   o_seg            - registered segments {g,f,e,d,c,b,a}, active-high
//   o_dig            - registered one-hot digit enable, bit k = digit k
// Optional build macro LIBSV_BCD_DISPLAY_SCANNER_LZB_EN enables leading-zero
// blanking of digits above digit 0.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int N_DIGITS     = 3,
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_aresetn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [4*N_DIGITS-1:0] i_bcd,
  output logic [6:0]            o_seg,
  output logic [N_DIGITS-1:0]   o_dig
);

  localparam int W        = 4 * N_DIGITS;
  localparam int CNT_SPAN = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_MAX  = (CNT_SPAN > 2) ? CNT_SPAN : 2;
  localparam int CW       = $clog2(CNT_MAX);
  localparam int IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam state_t RESET_STATE = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        disp_q, disp_d;
  logic [W-1:0]        pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] dig_q, dig_d;

  logic                last_digit;
  logic                digit_done;
  logic                boundary;
  logic                xfer;
  logic [3:0]          nibble;
  logic [6:0]          dec_seg;
  logic                lzb_blank;

  assign o_ready    = ~pend_vld_q;
  assign xfer       = i_valid & ~pend_vld_q;
  assign last_digit = (idx_q == IW'(N_DIGITS - 1));
  assign digit_done = (cnt_q == CW'(DIGIT_CYCLES - 1));
  assign boundary   = (state_q == DRIVE) & digit_done & last_digit;

  // Scan sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (digit_done) begin
          cnt_d   = '0;
          idx_d   = last_digit ? '0 : idx_q + IW'(1);
          state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        end
      end
      default: begin
        state_d = RESET_STATE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake and frame-boundary load. A transfer can never coincide with a
  // load because the load only happens while pending is full (o_ready low).
  always_comb begin
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (boundary && pend_vld_q) begin
      disp_d     = pend_q;
      pend_vld_d = 1'b0;
    end
    if (xfer) begin
      pend_d     = i_bcd;
      pend_vld_d = 1'b1;
    end
  end

  // Outputs are computed from next-state values so the registered o_dig/o_seg
  // line up with the registered state, and the first digit after a boundary
  // already sees the newly loaded word.
  always_comb begin
    nibble = disp_d[3:0];
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        nibble = disp_d[4*k +: 4];
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd (nibble),
    .seg (dec_seg)
  );

`ifdef LIBSV_BCD_DISPLAY_SCANNER_LZB_EN
  logic upper_zero;

  // Blank digit idx when it and all more significant digits are zero;
  // digit 0 always shows.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if ((IW'(k) >= idx_d) && (disp_d[4*k +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    lzb_blank = (idx_d != '0) && upper_zero;
  end
`else
  assign lzb_blank = 1'b0;
`endif

  always_comb begin
    seg_d = SEG_OFF;
    dig_d = '0;
    if (state_d == DRIVE) begin
      seg_d = lzb_blank ? SEG_OFF : dec_seg;
      for (int unsigned k = 0; k < N_DIGITS; k++) begin
        dig_d[k] = (idx_d == IW'(k));
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q    <= RESET_STATE;
      idx_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= SEG_OFF;
      dig_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign o_seg = seg_q;
  assign o_dig = dig_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: self-checking bench for bcd_display_scanner.
// Two instances share clock and reset: one with a blanking gap (B=1) driven
// by directed and random traffic, one with no gap (B=0) left idle.
// Honours LIBSV_BCD_DISPLAY_SCANNER_LZB_EN in its expectations.
module tb_bcd_display_scanner;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int B  = 1;
  localparam int F  = N * (B + D);
  localparam int F0 = N * D;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [11:0] bcd;
  logic        o_ready;
  logic [6:0]  o_seg;
  logic [2:0]  o_dig;
  logic        o_ready0;
  logic [6:0]  o_seg0;
  logic [2:0]  o_dig0;

  bcd_display_scanner #(
    .N_DIGITS     (N),
    .DIGIT_CYCLES (D),
    .BLANK_CYCLES (B)
  ) dut (
    .i_clk     (clk),
    .i_aresetn (rst_n),
    .i_valid   (valid),
    .o_ready   (o_ready),
    .i_bcd     (bcd),
    .o_seg     (o_seg),
    .o_dig     (o_dig)
  );

  bcd_display_scanner #(
    .N_DIGITS     (N),
    .DIGIT_CYCLES (D),
    .BLANK_CYCLES (0)
  ) dut_nogap (
    .i_clk     (clk),
    .i_aresetn (rst_n),
    .i_valid   (1'b0),
    .o_ready   (o_ready0),
    .i_bcd     (12'h000),
    .o_seg     (o_seg0),
    .o_dig     (o_dig0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycles since reset release, shown word, pending word.
  int          m_s;
  int          m_s0;
  logic [11:0] m_disp;
  logic [11:0] m_pend;
  bit          m_pfull;
  bit          m_xfer;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int k, input logic [11:0] v);
    logic [3:0] n;
`ifdef LIBSV_BCD_DISPLAY_SCANNER_LZB_EN
    logic [11:0] up;
    up = v >> (4 * k);
    if (k > 0 && up == 12'h000) return 7'h00;
`endif
    n = v[4*k +: 4];
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic compare();
    int pos, slot, off, pos0;
    logic [2:0] ed, ed0;
    logic [6:0] es, es0;
    pos  = m_s % F;
    slot = pos / (B + D);
    off  = pos % (B + D);
    if (off < B) begin
      ed = 3'b000;
      es = 7'h00;
    end else begin
      ed = 3'b001 << slot;
      es = seg_of(slot, m_disp);
    end
    check("dig", 32'(o_dig), 32'(ed));
    check("seg", 32'(o_seg), 32'(es));
    check("ready", 32'(o_ready), 32'(!m_pfull));
    pos0 = m_s0 % F0;
    if (m_s0 == 0) begin
      ed0 = 3'b000;
      es0 = 7'h00;
    end else begin
      ed0 = 3'b001 << (pos0 / D);
      es0 = seg_of(pos0 / D, 12'h000);
    end
    check("nogap_dig", 32'(o_dig0), 32'(ed0));
    check("nogap_seg", 32'(o_seg0), 32'(es0));
    check("nogap_ready", 32'(o_ready0), 32'd1);
  endtask

  // One clock: update the model at the edge, then compare on the falling edge.
  task automatic cycle();
    @(posedge clk);
    m_xfer = 1'b0;
    if (rst_n) begin
      m_xfer = valid && !m_pfull;
      if ((m_s % F) == F - 1 && m_pfull) begin
        m_disp  = m_pend;
        m_pfull = 1'b0;
      end
      if (m_xfer) begin
        m_pend  = bcd;
        m_pfull = 1'b1;
      end
      m_s++;
      m_s0++;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic model_reset();
    m_s     = 0;
    m_s0    = 0;
    m_disp  = '0;
    m_pend  = '0;
    m_pfull = 1'b0;
    m_xfer  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present a word and hold it until the model says it was taken.
  task automatic send(input logic [11:0] v);
    valid = 1'b1;
    bcd   = v;
    for (int i = 0; i < 4 * F; i++) begin
      cycle();
      if (m_xfer) break;
    end
    valid = 1'b0;
    bcd   = $urandom_range(0, 4095);
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 2 * F; i++) begin
      if ((m_s % F) == p) break;
      cycle();
    end
  endtask

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v;
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 9) < 2) v[4*k +: 4] = 4'($urandom_range(10, 15));
      else                          v[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    if ($urandom_range(0, 2) == 0) v[11:4] = 8'h00;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    bcd   = 12'h000;
    model_reset();
    @(negedge clk);
    compare();
    run(2);
    rst_n = 1'b1;

    // Idle frames after reset release
    run(2 * F);

    // Mid-frame transfer, then a second word held while pending is full
    wait_pos(3);
    send(12'h259);
    send(12'h111);
    run(2 * F);

    // Transfer landing exactly on the boundary cycle
    wait_pos(F - 1);
    valid = 1'b1;
    bcd   = 12'h0A3;
    cycle();
    valid = 1'b0;
    run(2 * F + 2);

    send(12'h007);
    run(2 * F);

    // Asynchronous reset during DRIVE of digit 1 with a word pending
    wait_pos(0);
    send(12'h345);
    wait_pos(B + D + B + 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_dig", 32'(o_dig), 32'd0);
    check("async_ready", 32'(o_ready), 32'd1);
    check("async_nogap_dig", 32'(o_dig0), 32'd0);
    run(2);
    rst_n = 1'b1;
    run(F + 2);

    // Randomised producer
    for (int i = 0; i < 400; i++) begin
      if (!valid && $urandom_range(0, 5) == 0) begin
        valid = 1'b1;
        bcd   = rand_bcd();
      end
      cycle();
      if (m_xfer) begin
        valid = 1'b0;
        bcd   = $urandom_range(0, 4095);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
